adc_spi_sched: RTL
==================

ADC_SPI_SCHED -- requirements
Module: adc_spi_sched

Interface
REQ-001 Parameter FRAME_MAX, default 16'd256: max data bytes sent per frame, range 1..65535.
REQ-002 Parameter HDR_EN, default 1: 1 = a header byte precedes each frame's data; 0 = no header.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ch0_full / ch1_full  in  1  channel FIFO full (frame ready).
REQ-006 ch0_empty / ch1_empty  in  1  channel FIFO empty.
REQ-007 ch0_rdata / ch1_rdata  in  8  FIFO read data; valid the cycle after a rd_en pulse.
REQ-008 ch0_rd_en / ch1_rd_en  out  1  FIFO read strobe; one-cycle pulse per byte.
REQ-009 ch0_wr_en / ch1_wr_en  out  1  FIFO write enable (ADC capture allowed).
REQ-010 aclk_in  in  1  asynchronous acquisition trigger; rearms capture.
REQ-011 spi_ready  in  1  serializer idle; drops the cycle after spi_start, high again when the byte is shifted out.
REQ-012 spi_start  out  1  one-cycle start pulse to the serializer.
REQ-013 spi_data  out  8  byte to send; held stable from spi_start until spi_ready returns high.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 active_ch  out  1  channel currently granted (last granted while IDLE).
REQ-016 frame_seq  out  4  count of completed frames, wraps 15 -> 0.

Function
REQ-017 States: IDLE, HDR, POP, LOAD, SEND, WAIT, REARM; all outputs registered.
REQ-018 IDLE: on the edge that samples any chX_full=1, grant a channel, clear its wr_en and go to HDR (HDR_EN=1) or POP (HDR_EN=0).
REQ-019 Arbitration: if only one full, grant it; if both full, grant the channel not granted last; after reset ch0 wins a tie.
REQ-020 HDR: when spi_ready=1, drive spi_data = {1'b1, 2'b00, active_ch, frame_seq} with spi_start for one cycle, then go to WAIT.
REQ-021 POP: if granted empty=1 or byte count = FRAME_MAX, go to REARM without reading; otherwise pulse rd_en one cycle and go to LOAD.
REQ-022 POP: empty=1 takes priority over a simultaneous full=1 on the same channel.
REQ-023 LOAD: capture granted rdata into spi_data; go to SEND.
REQ-024 SEND: when spi_ready=1, pulse spi_start, increment the 16-bit byte count and go to WAIT.
REQ-025 WAIT: ignore spi_ready in its first cycle; then, on spi_ready=1, go to POP.
REQ-026 Byte count clears on each grant; header bytes are not counted.
REQ-027 aclk_in passes through a 2-flop synchronizer, then a third flop; a falling edge is prev=1, cur=0.
REQ-028 REARM: increment frame_seq on entry; wait for a falling edge detected while in REARM (earlier edges ignored); then set the granted wr_en=1, record the channel as last granted and go to IDLE.
REQ-029 The non-granted channel keeps wr_en=1 and rd_en=0 throughout.
REQ-030 rd_en and spi_start are never high in the same cycle, and never high in consecutive cycles for the same byte.

Reset
REQ-031 rst=1 at an edge, in any state (including mid-frame), forces:
- state IDLE
- ch0_wr_en = ch1_wr_en = 1
- rd_en = 0, spi_start = 0, spi_data = 8'h00
- busy = 0, active_ch = 0, frame_seq = 0, byte count = 0
- last-granted = 1, synchronizer flops = 0
REQ-032 A partially sent frame is abandoned; no completion pulse and no frame_seq increment occur.

Verification
REQ-033 ch0_full=1, ch0 holds 3 bytes 11,22,33, HDR_EN=1, serializer busy 4 cycles/byte -> spi_data 0x80,0x11,0x22,0x33 in order; 3 ch0_rd_en pulses; frame_seq=1 after the aclk_in fall.
REQ-034 Both full in one cycle after reset -> ch0 granted first; when both full again after the frame, ch1 is granted.
REQ-035 FRAME_MAX=2, ch1 holds 5 bytes -> exactly 2 data bytes sent, then REARM with ch1_wr_en still 0 until an aclk_in fall.
REQ-036 aclk_in falls during data send, and again only after REARM entry -> only the second fall rearms; wr_en returns 1 three to four cycles after it.
REQ-037 rst=1 for one cycle during WAIT of the 2nd byte -> the next cycle shows all REQ-031 values; a new full restarts with header seq 0.
REQ-038 frame_seq wrap: 16 back-to-back frames -> the 17th header byte carries seq 0.

Source files
------------

// File: rtl/adc_spi_sched.sv
// adc_spi_sched: arbitrates between two ADC channel FIFOs and streams one
// frame at a time (optional header byte plus up to FRAME_MAX data bytes)
// into a byte-wide SPI serializer. After a frame, the granted channel stays
// blocked from capture until the next falling edge of the acquisition
// trigger is seen.
module adc_spi_sched #(
  parameter logic [15:0] FRAME_MAX = 16'd256,
  parameter bit          HDR_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch0_full,
  input  logic       ch1_full,
  input  logic       ch0_empty,
  input  logic       ch1_empty,
  input  logic [7:0] ch0_rdata,
  input  logic [7:0] ch1_rdata,
  output logic       ch0_rd_en,
  output logic       ch1_rd_en,
  output logic       ch0_wr_en,
  output logic       ch1_wr_en,
  input  logic       aclk_in,
  input  logic       spi_ready,
  output logic       spi_start,
  output logic [7:0] spi_data,
  output logic       busy,
  output logic       active_ch,
  output logic [3:0] frame_seq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_POP,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_REARM
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  wr_en_q, wr_en_d;
  logic [1:0]  rd_en_q, rd_en_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_data_q, spi_data_d;
  logic        busy_q;
  logic        active_q, active_d;
  logic        last_q, last_d;
  // Marks the first cycle spent in LOAD or WAIT.
  logic        first_q, first_d;
  logic [3:0]  seq_q, seq_d;
  logic [15:0] cnt_q, cnt_d;

  logic        sync1_q, sync2_q, prev_q;
  logic        aclk_fall;
  logic        grant;
  logic        g_empty;
  logic [7:0]  g_rdata;

  // Falling edge of the synchronized trigger: previous sample high, current low.
  assign aclk_fall = prev_q & ~sync2_q;

  // Single full channel wins outright; on a tie the channel not granted last wins.
  assign grant   = (ch0_full && ch1_full) ? ~last_q : ch1_full;
  assign g_empty = active_q ? ch1_empty : ch0_empty;
  assign g_rdata = active_q ? ch1_rdata : ch0_rdata;

  // Two-flop synchronizer for the asynchronous trigger plus one history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: every flop here is written with <= so all of them sample the
      // pre-edge values; blocking '=' would collapse the chain into one stage.
      sync1_q <= aclk_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state and registered-output computation for the frame FSM.
  always_comb begin
    // NOTE: every variable written below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = 2'b00;
    spi_start_d = 1'b0;
    spi_data_d  = spi_data_q;
    active_d    = active_q;
    last_d      = last_q;
    first_d     = 1'b0;
    seq_d       = seq_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ch0_full || ch1_full) begin
          active_d       = grant;
          wr_en_d[grant] = 1'b0;
          cnt_d          = 16'd0;
          state_d        = HDR_EN ? S_HDR : S_POP;
        end
      end
      S_HDR: begin
        if (spi_ready) begin
          spi_data_d  = {1'b1, 2'b00, active_q, seq_q};
          spi_start_d = 1'b1;
          first_d     = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_POP: begin
        // Empty wins over full, and the frame ends at FRAME_MAX data bytes.
        if (g_empty || (cnt_q == FRAME_MAX)) begin
          seq_d   = seq_q + 4'd1;
          state_d = S_REARM;
        end else begin
          rd_en_d[active_q] = 1'b1;
          first_d           = 1'b1;
          state_d           = S_LOAD;
        end
      end
      S_LOAD: begin
        // The strobe is on the wire during the first LOAD cycle, so the FIFO
        // presents the byte one cycle later; capture it then.
        if (!first_q) begin
          spi_data_d = g_rdata;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (spi_ready) begin
          spi_start_d = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          first_d     = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // spi_ready is still high from before the start pulse in the first cycle.
        if (!first_q && spi_ready) begin
          state_d = S_POP;
        end
      end
      S_REARM: begin
        if (aclk_fall) begin
          wr_en_d[active_q] = 1'b1;
          last_d            = active_q;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_en_q     <= 2'b11;
      rd_en_q     <= 2'b00;
      spi_start_q <= 1'b0;
      spi_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      active_q    <= 1'b0;
      last_q      <= 1'b1;
      first_q     <= 1'b0;
      seq_q       <= 4'd0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      busy_q      <= (state_d != S_IDLE);
      active_q    <= active_d;
      last_q      <= last_d;
      first_q     <= first_d;
      seq_q       <= seq_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ch0_wr_en = wr_en_q[0];
  assign ch1_wr_en = wr_en_q[1];
  assign ch0_rd_en = rd_en_q[0];
  assign ch1_rd_en = rd_en_q[1];
  assign spi_start = spi_start_q;
  assign spi_data  = spi_data_q;
  assign busy      = busy_q;
  assign active_ch = active_q;
  assign frame_seq = seq_q;

endmodule
